// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_if
//  Description : Bundle of the E-stage request and result signals exchanged
//                with the multiply/divide unit controller.
//                master : pipeline side (drives MDUOp, A, B, Flush, RdSel)
//                slave  : mdu_ctrl side (drives Busy, Start, HI, LO, MDU_Out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_ctrl_if;
  logic [2:0]  MDUOp;    // E-stage operation code
  logic [31:0] A;        // forwarded rs
  logic [31:0] B;        // forwarded rt
  logic        Flush;    // cancel the E-stage operation this cycle
  logic        RdSel;    // 1: read HI, 0: read LO
  logic        Busy;     // mult/div in flight (registered)
  logic        Start;    // mult/div accepted this cycle (combinational)
  logic [31:0] HI;       // architectural HI
  logic [31:0] LO;       // architectural LO
  logic [31:0] MDU_Out;  // mfhi/mflo read data

  modport master (
    output MDUOp, A, B, Flush, RdSel,
    input  Busy, Start, HI, LO, MDU_Out
  );

  modport slave (
    input  MDUOp, A, B, Flush, RdSel,
    output Busy, Start, HI, LO, MDU_Out
  );
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multi-cycle multiply/divide controller with HI/LO registers.
//                The result is computed when the operation is accepted, held
//                in TmpHI/TmpLO, and committed to HI/LO after a fixed busy
//                period (MULT_CYCLES or DIV_CYCLES).
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-low reset
//                bus   - mdu_ctrl_if.slave (MDUOp/A/B/Flush/RdSel in,
//                        Busy/Start/HI/LO/MDU_Out out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mdu_ctrl_if.slave   bus
);

  localparam logic [2:0] c_op_mult  = 3'b001;
  localparam logic [2:0] c_op_multu = 3'b010;
  localparam logic [2:0] c_op_div   = 3'b011;
  localparam logic [2:0] c_op_divu  = 3'b100;
  localparam logic [2:0] c_op_mthi  = 3'b101;
  localparam logic [2:0] c_op_mtlo  = 3'b110;

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_skip_commit;   // divide-by-zero: keep HI/LO at completion
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_tmp_hi;
  logic [31:0] r_tmp_lo;

  logic        w_is_muldiv;
  logic        w_start;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_done;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_ovf;
  logic [31:0] w_divisor;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div_zero;
  logic [3:0]  w_load_cnt;

  // --------------------------------------------------------------------------
  // Result datapath (evaluated on the E-stage operands)
  // --------------------------------------------------------------------------
  assign w_prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // A zero divisor is replaced so the dividers never see it; the commit is
  // skipped anyway in that case.
  assign w_divisor = (bus.B == 32'd0) ? 32'd1 : bus.B;

  // -2^31 / -1 overflows 32 bits; define it as quotient -2^31, remainder 0.
  assign w_div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
  assign w_quot_s  = w_div_ovf ? 32'h8000_0000 : 32'($signed(bus.A) / $signed(w_divisor));
  assign w_rem_s   = w_div_ovf ? 32'd0         : 32'($signed(bus.A) % $signed(w_divisor));
  assign w_quot_u  = bus.A / w_divisor;
  assign w_rem_u   = bus.A % w_divisor;

  always_comb begin
    w_res_hi   = 32'd0;
    w_res_lo   = 32'd0;
    w_div_zero = 1'b0;
    w_load_cnt = c_mult_cnt;
    case (bus.MDUOp)
      c_op_mult: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      c_op_multu: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      c_op_div: begin
        w_res_hi   = w_rem_s;
        w_res_lo   = w_quot_s;
        w_div_zero = (bus.B == 32'd0);
        w_load_cnt = c_div_cnt;
      end
      c_op_divu: begin
        w_res_hi   = w_rem_u;
        w_res_lo   = w_quot_u;
        w_div_zero = (bus.B == 32'd0);
        w_load_cnt = c_div_cnt;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (w_start) w_next_state = c_run;
      c_run:   if (w_done)  w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // FSM: outputs / decoded actions
  always_comb begin
    w_is_muldiv = (bus.MDUOp >= c_op_mult) && (bus.MDUOp <= c_op_divu);
    w_start     = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      c_idle: begin
        w_start = w_is_muldiv && !bus.Flush;
        w_mthi  = (bus.MDUOp == c_op_mthi) && !bus.Flush;
        w_mtlo  = (bus.MDUOp == c_op_mtlo) && !bus.Flush;
      end
      c_run: begin
        // Flush does not reach here: an operation in RUN always completes.
        w_done = (r_cnt == 4'd1);
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counter, busy flag, temporary result and HI/LO registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= 4'd0;
      r_busy        <= 1'b0;
      r_skip_commit <= 1'b0;
      r_tmp_hi      <= 32'd0;
      r_tmp_lo      <= 32'd0;
      r_hi          <= 32'd0;
      r_lo          <= 32'd0;
    end else begin
      if (w_start) begin
        r_tmp_hi      <= w_res_hi;
        r_tmp_lo      <= w_res_lo;
        r_skip_commit <= w_div_zero;
        r_cnt         <= w_load_cnt;
        r_busy        <= 1'b1;
      end else if (r_state == c_run) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_done) begin
          r_busy <= 1'b0;
          if (!r_skip_commit) begin
            r_hi <= r_tmp_hi;
            r_lo <= r_tmp_lo;
          end
        end
      end else begin
        if (w_mthi) r_hi <= bus.A;
        if (w_mtlo) r_lo <= bus.A;
      end
    end
  end

  assign bus.Start   = w_start;
  assign bus.Busy    = r_busy;
  assign bus.HI      = r_hi;
  assign bus.LO      = r_lo;
  // Architectural value only; an in-flight result is never forwarded.
  assign bus.MDU_Out = bus.RdSel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning Busy duration of mult/multu in cycles (range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning Busy duration of div/divu in cycles (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port MDUOp, input, 3, E-stage operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
REQ-006 SHALL have port A, input, 32, forwarded rs value from E stage.
REQ-007 SHALL have port B, input, 32, forwarded rt value from E stage.
REQ-008 SHALL have port Flush, input, 1, an exception or interrupt is taken this cycle, so the E-stage MDUOp is cancelled.
REQ-009 SHALL have port RdSel, input, 1, mfhi/mflo selector: 1 selects HI, 0 selects LO.
REQ-010 SHALL have port Busy, output, 1, registered flag: a mult or div is in flight (feeds the hazard unit busy input).
REQ-011 SHALL have port Start, output, 1, combinational flag: a mult/multu/div/divu is accepted this cycle (hazard unit stalls on Start or Busy).
REQ-012 SHALL have port HI, output, 32, architectural HI register.
REQ-013 SHALL have port LO, output, 32, architectural LO register.
REQ-014 SHALL have port MDU_Out, output, 32, combinational output: HI when RdSel=1, else LO.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 SHALL assert Start only when state is IDLE, MDUOp is in 001..100, and Flush=0.
REQ-017 On a Start edge: SHALL compute the 64-bit result from A and B, latch it into internal registers TmpHI/TmpLO, load the 4-bit counter with MULT_CYCLES or DIV_CYCLES, set Busy=1, and enter RUN.
REQ-018 mult/multu: TmpHI/TmpLO SHALL hold the upper/lower 32 bits of the signed/unsigned 64-bit product.
REQ-019 div/divu: TmpLO SHALL be the quotient and TmpHI the remainder, signed or unsigned as decoded. Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-020 Division by zero: HI and LO SHALL remain unchanged at completion. Busy timing SHALL be identical to a normal div.
REQ-021 In RUN: the counter SHALL decrement on each edge. On the edge where the counter goes 1->0, HI/LO SHALL load TmpHI/TmpLO, Busy SHALL clear, and the FSM SHALL return to IDLE. Busy is therefore high for exactly N cycles after the Start cycle.
REQ-022 mthi/mtlo in IDLE with Flush=0: SHALL write A into HI/LO on the next edge. Busy is unaffected.
REQ-023 Any MDUOp other than none while in RUN SHALL be ignored: no state change, no HI/LO write.
REQ-024 Flush=1 SHALL suppress Start and mthi/mtlo in the same cycle. Flush SHALL NOT abort an operation already in RUN; it completes and commits normally.
REQ-025 HI/LO SHALL change only on completion (REQ-021) or on mthi/mtlo (REQ-022).
REQ-026 MDU_Out SHALL reflect HI/LO as registered, with no bypass of an in-flight result.

Reset
REQ-027 When reset=0, asynchronously: HI, LO, TmpHI and TmpLO SHALL be 0, the counter 0, Busy 0, and state IDLE. Start SHALL then evaluate from inputs.
REQ-028 Reset asserted mid-RUN SHALL discard the in-flight result. HI/LO SHALL read 0 after release.
REQ-029 After reset deasserts, the first Start SHALL be accepted on the first rising clk edge.

Verification
REQ-030 mult A=0xFFFFFFFD, B=5 -> Start=1 for 1 cycle, Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, Busy=0.
REQ-031 div A=7, B=0xFFFFFFFE -> Busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=1. divu A=0xFFFFFFFF, B=2 -> LO=0x7FFFFFFF, HI=1.
REQ-032 mthi A=0x12345678, then divu B=0 -> Busy=1 for 10 cycles, HI stays 0x12345678, LO stays prior value. RdSel=1 gives MDU_Out=0x12345678.
REQ-033 multu with Flush=1 in the same cycle -> Start=0, Busy stays 0, HI/LO unchanged. Flush=1 at RUN cycle 3 -> the op still completes at cycle 5.
REQ-034 mult issued and mtlo presented during RUN -> the mtlo is ignored. Reset=0 at RUN cycle 2 -> Busy=0, HI=LO=0 immediately; no commit after release.
